sram_burst_arbiter: RTL

- Shares one single-port BRAM, and the sram_buffer read register behind it, between two requesters (e.g. weight loader, activation feeder).
- Accepts whole-burst requests and arbitrates them round-robin.
- Generates the per-beat BRAM ena/wea/addra/dina.
- Tags in-flight reads so buffered read data returns to the right requester with a valid strobe.

---
 rtl/sram_burst_arbiter_pkg.sv | 17 +
 rtl/sram_rd_tag_pipe.sv | 20 ++
 rtl/sram_burst_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_burst_arbiter_pkg.sv
// Shared widths, FSM state encoding and read-tag layout for the SRAM burst arbiter.
package sram_burst_arbiter_pkg;
  localparam int BIT_DATA    = 16;
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_LEN_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic vld;
    logic id;
    logic last;
  } rd_tag_t;
endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Two-stage {valid,id,last} shift register aligning read tags with the BRAM + buffer latency.
module sram_rd_tag_pipe
  import sram_burst_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t stage0,
  output rd_tag_t stage1
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0 <= '0;
      stage1 <= '0;
    end else begin
      stage0 <= tag_in;
      stage1 <= stage0;
    end
  end
endmodule

// File: rtl/sram_burst_arbiter.sv
// Round-robin burst arbiter sharing one single-port BRAM between two requesters.
// One beat per cycle inside a burst, one idle arbitration cycle between bursts.
module sram_burst_arbiter
  import sram_burst_arbiter_pkg::*;
#(
  parameter int WIDTH  = BIT_DATA,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int LEN_W  = SRAM_LEN_W
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic [1:0]          rq_valid,
  input  logic [1:0]          rq_we,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*LEN_W-1:0]  rq_len,
  output logic [1:0]          rq_ready,
  input  logic [2*WIDTH-1:0]  wr_data,
  output logic [1:0]          wr_beat,
  output logic [WIDTH-1:0]    rd_data,
  output logic [1:0]          rd_valid,
  output logic                rd_last,
  output logic                busy,
  output logic                ena,
  output logic                wea,
  output logic [ADDR_W-1:0]   addra,
  output logic [WIDTH-1:0]    dina,
  input  logic [WIDTH-1:0]    douta_buf
);
  state_t              state;
  logic                rr_ptr;
  logic                gid_q;
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;

  logic                grant_vld;
  logic                grant_id;
  logic                in_burst;
  logic                last_beat;
  logic [WIDTH-1:0]    wr_sel;
  rd_tag_t             tag_in;
  rd_tag_t             stage0;
  rd_tag_t             stage1;

  // Pointer only matters when both requesters compete.
  always_comb begin
    grant_id = 1'b0;
    case (rq_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = rr_ptr;
      default: grant_id = 1'b0;
    endcase
  end

  assign grant_vld = (state == ST_IDLE) && (|rq_valid) && !rsta;
  assign rq_ready  = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign in_burst  = (state == ST_BURST);
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clka) begin
    if (rsta) begin
      state  <= ST_IDLE;
      rr_ptr <= 1'b0;
      gid_q  <= 1'b0;
      we_q   <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            state  <= ST_BURST;
            gid_q  <= grant_id;
            we_q   <= rq_we[grant_id];
            base_q <= grant_id ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
            len_q  <= grant_id ? rq_len[2*LEN_W-1:LEN_W] : rq_len[LEN_W-1:0];
            cnt_q  <= '0;
            rr_ptr <= ~grant_id;
          end
        end
        ST_BURST: begin
          if (last_beat) state <= ST_IDLE;
          else           cnt_q <= cnt_q + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address wraps modulo the BRAM depth.
  assign wr_sel  = gid_q ? wr_data[2*WIDTH-1:WIDTH] : wr_data[WIDTH-1:0];
  assign ena     = in_burst;
  assign wea     = in_burst & we_q;
  assign addra   = in_burst ? base_q + ADDR_W'(cnt_q) : '0;
  assign dina    = wea ? wr_sel : '0;
  assign wr_beat = wea ? (gid_q ? 2'b10 : 2'b01) : 2'b00;

  assign tag_in = '{vld: in_burst & ~we_q, id: gid_q, last: last_beat};

  sram_rd_tag_pipe u_tag_pipe (
    .clk    (clka),
    .rst    (rsta),
    .tag_in (tag_in),
    .stage0 (stage0),
    .stage1 (stage1)
  );

  assign rd_data  = douta_buf;
  assign rd_valid = {stage1.vld & stage1.id, stage1.vld & ~stage1.id};
  assign rd_last  = stage1.vld & stage1.last;
  assign busy     = in_burst | stage0.vld | stage1.vld;
endmodule
